// File: rtl/stream_decipher_framed.sv
// Framed stream decipher: KEY, LEN, payload (+CHK when STREAM_DECIPHER_CHECKSUM_EN); p = c ^ SBOX[KEY+i].
// One cycle accept-to-m_valid latency; single output register, s_ready drops only while that register is stalled.
module stream_decipher_framed #(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_done,
  output logic       err
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAY, S_CHK} state_t;

  state_t               state;
  logic [7:0]           key;
  logic [7:0]           len;
  logic [7:0]           idx;
  logic [TIMEOUT_W-1:0] idle_cnt;
  logic                 accept;
  logic                 timeout_hit;
  logic                 last_pay;
  logic [7:0]           sbox_idx;
  logic [7:0]           plain;
`ifdef STREAM_DECIPHER_CHECKSUM_EN
  logic [7:0]           chk;
`endif

  always_comb begin
    s_ready     = (state == S_PAY) ? (!m_valid || m_ready) : 1'b1;
    accept      = s_valid && s_ready;
    sbox_idx    = key + idx;
    plain       = s_data ^ SBOX[sbox_idx];
    last_pay    = (idx == len - 8'd1);
    timeout_hit = (TIMEOUT != 0) && (state != S_IDLE) && !accept &&
                  (idle_cnt == TIMEOUT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      key        <= 8'd0;
      len        <= 8'd0;
      idx        <= 8'd0;
      idle_cnt   <= '0;
      m_valid    <= 1'b0;
      m_data     <= 8'd0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
`ifdef STREAM_DECIPHER_CHECKSUM_EN
      chk        <= 8'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (m_valid && m_ready)
        m_valid <= 1'b0;
      if (accept || state == S_IDLE)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      case (state)
        S_IDLE: if (accept) begin
          key   <= s_data;
          idx   <= 8'd0;
          state <= S_LEN;
`ifdef STREAM_DECIPHER_CHECKSUM_EN
          chk   <= 8'd0;
`endif
        end
        S_LEN: if (accept) begin
          len <= s_data;
          if (s_data == 8'd0) begin
`ifdef STREAM_DECIPHER_CHECKSUM_EN
            state      <= S_CHK;
`else
            state      <= S_IDLE;
            frame_done <= 1'b1;
`endif
          end else begin
            state <= S_PAY;
          end
        end
        S_PAY: if (accept) begin
          // A new load overrides the clear above, so a simultaneous drain and load never bubbles.
          m_data  <= plain;
          m_valid <= 1'b1;
          m_last  <= last_pay;
          idx     <= idx + 8'd1;
`ifdef STREAM_DECIPHER_CHECKSUM_EN
          chk     <= chk ^ plain;
          if (last_pay)
            state <= S_CHK;
`else
          if (last_pay) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
          end
`endif
        end
`ifdef STREAM_DECIPHER_CHECKSUM_EN
        S_CHK: if (accept) begin
          state <= S_IDLE;
          if (s_data == chk)
            frame_done <= 1'b1;
          else
            err <= 1'b1;
        end
`endif
        default: state <= S_IDLE;
      endcase

      // Drop the partial frame but leave any held output byte to drain normally.
      if (timeout_hit) begin
        err      <= 1'b1;
        state    <= S_IDLE;
        idle_cnt <= '0;
      end
    end
  end

endmodule
